// File: rtl/mem_bridge_pkg.sv
// Shared types for the core-to-bus memory bridge.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_SIZE_BYTE = 2'd0,
    MEM_ACCESS_SIZE_HALF = 2'd1,
    MEM_ACCESS_SIZE_WORD = 2'd2
  } mem_access_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } mem_bridge_state_t;

  // Request context that must survive past the accepting cycle.
  typedef struct packed {
    logic             we;
    logic [1:0]       addr_lo;
    mem_access_size_t size;
  } mem_req_t;

  localparam int unsigned MB_MIN_CNT_W = 8;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: write strobes/data placement, read extraction, alignment check.
module mem_lane_align
  import mem_bridge_pkg::*;
(
  input  mem_access_size_t size,
  input  logic [1:0]       addr_lo,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rdata,
  output logic [3:0]       strb,
  output logic [31:0]      wdata_lane,
  output logic [31:0]      rdata_ext,
  output logic             misaligned
);

  logic [31:0] rshift;
  assign rshift = rdata >> {addr_lo, 3'b000};

  always_comb begin
    strb       = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    misaligned = |addr_lo;
    case (size)
      MEM_ACCESS_SIZE_BYTE: begin
        strb       = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {24'b0, rshift[7:0]};
        misaligned = 1'b0;
      end
      MEM_ACCESS_SIZE_HALF: begin
        strb       = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {16'b0, rshift[15:0]};
        misaligned = addr_lo[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bridge.sv
// Core memory port to word-wide valid/ready bus bridge with read-response strobe.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             rd_req_i,
  input  logic [31:0]      rd_addr_i,
  input  mem_access_size_t rd_size_i,
  input  logic             wr_enable_i,
  input  logic [31:0]      wr_addr_i,
  input  logic [31:0]      wr_data_i,
  input  mem_access_size_t wr_size_i,
  output logic [31:0]      rd_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             bus_valid_o,
  input  logic             bus_ready_i,
  output logic             bus_we_o,
  output logic [31:0]      bus_addr_o,
  output logic [31:0]      bus_wdata_o,
  output logic [3:0]       bus_strb_o,
  input  logic [31:0]      bus_rdata_i,
  input  logic             bus_rvalid_i
);

  localparam int unsigned CW    = ($clog2(TIMEOUT + 1) > MB_MIN_CNT_W) ?
                                  $clog2(TIMEOUT + 1) : MB_MIN_CNT_W;
  localparam int unsigned TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(TLAST);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  mem_bridge_state_t state_q, state_d;
  mem_req_t          req_q;
  logic [CW-1:0]     cnt_q;
  logic              err_q;
  logic [31:0]       rd_data_q, bus_addr_q, bus_wdata_q;
  logic [3:0]        bus_strb_q;

  logic              new_req, tmo;
  logic [31:0]       in_addr;
  mem_access_size_t  in_size, sel_size;
  logic [1:0]        sel_lo;
  logic [3:0]        al_strb;
  logic [31:0]       al_wdata, al_rdata;
  logic              al_mis;

  // Writes win a simultaneous request; the read is simply not taken.
  assign new_req = wr_enable_i | rd_req_i;
  assign in_addr = wr_enable_i ? wr_addr_i : rd_addr_i;
  assign in_size = wr_enable_i ? wr_size_i : rd_size_i;

  // The aligner sees the incoming request while idle (for placement and the
  // alignment check) and the latched request afterwards (for read extraction).
  assign sel_size = (state_q == ST_IDLE) ? in_size : req_q.size;
  assign sel_lo   = (state_q == ST_IDLE) ? in_addr[1:0] : req_q.addr_lo;

  mem_lane_align u_align (
    .size       (sel_size),
    .addr_lo    (sel_lo),
    .wdata      (wr_data_i),
    .rdata      (bus_rdata_i),
    .strb       (al_strb),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_mis)
  );

  assign tmo = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (new_req) state_d = al_mis ? ST_DONE : ST_REQ;
      ST_REQ: begin
        if (bus_ready_i) state_d = req_q.we ? ST_DONE : ST_RESP;
        else if (tmo)    state_d = ST_DONE;
      end
      ST_RESP: if (bus_rvalid_i || tmo) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q == ST_REQ) || (state_q == ST_RESP);
    done_o      = (state_q == ST_DONE);
    err_o       = (state_q == ST_DONE) && err_q;
    bus_valid_o = (state_q == ST_REQ);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rd_data_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_strb_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (new_req) begin
          req_q.we      <= wr_enable_i;
          req_q.addr_lo <= in_addr[1:0];
          req_q.size    <= in_size;
          bus_addr_q    <= {in_addr[31:2], 2'b00};
          bus_wdata_q   <= wr_enable_i ? al_wdata : '0;
          bus_strb_q    <= wr_enable_i ? al_strb : 4'b0000;
          err_q         <= al_mis;
          cnt_q         <= '0;
          if (al_mis) rd_data_q <= '0;
        end
        ST_REQ: begin
          if (bus_ready_i) cnt_q <= '0;
          else if (tmo) begin
            err_q     <= 1'b1;
            rd_data_q <= '0;
          end else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        end
        ST_RESP: begin
          if (bus_rvalid_i) rd_data_q <= al_rdata;
          else if (tmo) begin
            err_q     <= 1'b1;
            rd_data_q <= '0;
          end else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_data_o   = rd_data_q;
  assign bus_we_o    = req_q.we;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_strb_o  = bus_strb_q;

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Adapts the core's memory port to a single-ported, word-wide external bus with a valid/ready request handshake and a separate read-response strobe. Sits directly downstream of the core datapath's memory port and upstream of RAM/peripherals. Converts byte/half/word accesses to aligned word transactions with byte strobes, and extracts sub-word read data. Sequences each access through a small FSM, and reports busy/done/error back to the control unit, which holds the core while `busy_o` is high.

## Interface
- `TIMEOUT`, 255: maximum cycles spent in REQ or RESP before aborting with error; 0 disables the timeout.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `rd_req_i`  in  1  read request (level).
- `rd_addr_i`  in  32  read byte address.
- `rd_size_i`  in  `mem_access_size_t`  read size.
- `wr_enable_i`  in  1  write request (level).
- `wr_addr_i`  in  32  write byte address.
- `wr_data_i`  in  32  write data, right-aligned.
- `wr_size_i`  in  `mem_access_size_t`  write size.
- `rd_data_o`  out  32  read data, zero-extended, right-aligned.
- `busy_o`  out  1  transaction in progress (state != IDLE and != DONE).
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  valid with `done_o`: misaligned access or timeout.
- `bus_valid_o`  out  1  request valid.
- `bus_ready_i`  in  1  request accepted.
- `bus_we_o`  out  1  1 = write.
- `bus_addr_o`  out  32  word address, bits [1:0] always 0.
- `bus_wdata_o`  out  32  lane-positioned write data.
- `bus_strb_o`  out  4  byte strobes; 4'b0000 on reads.
- `bus_rdata_i`  in  32  read response data.
- `bus_rvalid_i`  in  1  read response valid.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- **IDLE, accepting a request:**
  - `wr_enable_i` has priority over `rd_req_i`. A read asserted together with a write is not served and must be re-asserted after the write's `done_o`.
  - The accepting cycle latches the operation, address, size and write data. Later input changes are ignored until DONE.
  - Misaligned access goes straight to DONE with error and issues no bus transaction. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - Otherwise go to REQ.
- **REQ:**
  - `bus_valid_o`=1; addr, we, wdata and strb stay stable until `bus_ready_i`.
  - On handshake: a write goes to DONE; a read goes to RESP.
- **RESP:** waits for `bus_rvalid_i`, which is sampled only in this state. On rvalid, capture the extracted lane into `rd_data_o`, then go to DONE.
- **Timeout:** a counter is cleared on entry to REQ and to RESP. If it reaches `TIMEOUT` (≠0) before the exit event, go to DONE with `err_o`=1, `bus_valid_o` drops, and `rd_data_o` is set to 0.
- **DONE:** `done_o`=1 for one cycle, then IDLE.
  - The requester must deassert its request in the `done_o` cycle. A request still high in the following IDLE cycle starts a new transaction.
- **Write lanes** (`a` = addr[1:0]):
  - byte: strb = 4'b0001<<a, wdata = {4{d[7:0]}}.
  - half: strb = 4'b0011<<a, wdata = {2{d[15:0]}}.
  - word: strb = 4'b1111, wdata = d.
- **Read extraction:**
  - byte: `bus_rdata_i[8a+7:8a]`.
  - half: `bus_rdata_i[8a+15:8a]`.
  - Both are zero-extended. Sign extension is done in the datapath.
- `rd_data_o` holds its value until the next read completes or an error occurs.

## Timing
- All outputs are registered or derived from registered state only. There is no combinational path from bus inputs to bus outputs.
- Reset values: state IDLE, counter 0, all outputs 0 (`rd_data_o`=0, `bus_addr_o`=0).
- Reset mid-transaction aborts immediately: at the reset edge `bus_valid_o` drops and no `done_o` is produced. The bus slave must tolerate the abandoned request.
- Write latency with `bus_ready_i` tied high:
  - request seen in IDLE at cycle 0;
  - REQ with valid at cycle 1 (handshake);
  - `done_o` at cycle 2.
- Read with ready high and rvalid one cycle after handshake: REQ at cycle 1, RESP at cycle 2 (rvalid), `done_o` at cycle 3.
- Misaligned access: `done_o`+`err_o` in cycle 1 and `bus_valid_o` never rises.
- The timeout counter is 8 bits wide or `$clog2(TIMEOUT+1)`, whichever is larger. It must not wrap.

## Structure
- Shared definitions package:
  - `mem_access_size_t` {MEM_ACCESS_SIZE_BYTE, MEM_ACCESS_SIZE_HALF, MEM_ACCESS_SIZE_WORD}, 2 bits;
  - `mem_bridge_state_t`.
- One combinational sub-module, `mem_lane_align`:
  - inputs: size, addr[1:0], wdata, rdata;
  - outputs: strb, positioned wdata, extracted rdata, misaligned flag.
- The FSM, latches and timeout counter stay in `mem_bridge`.

## Test plan
- Word write to 0x00010004 of 0xDEADBEEF, ready high → bus addr 0x00010004, strb 4'b1111, wdata 0xDEADBEEF; `done_o` at cycle 2, `err_o`=0.
- Byte write of 0x000000A5 to 0x00010007 → strb 4'b1000, wdata 0xA5A5A5A5.
- Half read at 0x00010002, `bus_rdata_i`=0x8123_4567, rvalid after 3 wait cycles → `rd_data_o`=0x00008123; `busy_o` high throughout; single `done_o`.
- Word read at 0x00010001 → `done_o`+`err_o` in cycle 1, no `bus_valid_o`, `rd_data_o`=0.
- `bus_ready_i` held low, TIMEOUT=4 → `bus_valid_o` high for 4 cycles, then `done_o`+`err_o`; `bus_addr_o`/`bus_wdata_o` stable throughout.
- `rd_req_i` and `wr_enable_i` together, with `reset_i` pulsed during REQ of the write → no `done_o`, all outputs 0 next cycle, and a subsequent read completes normally.
